// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg: shared types and constants for the instruction-fetch stage.
//   XLEN         : architectural word width
//   NOP_INSTR    : instruction presented when no valid fetch is available
//   IF_RESET_PC  : default fetch PC after reset
//   if_entry_t   : prefetch queue payload {pc, instr}
//   word_align() : clears the byte offset of an address
// -----------------------------------------------------------------------------
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// -----------------------------------------------------------------------------
// if_fifo: prefetch queue for the fetch stage, DEPTH entries of if_entry_t.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data at the tail
//   pop        : retire the head entry
//   flush      : empty the queue (wins over push/pop)
//   push_data  : entry to write
//   head       : current head entry (undefined content when empty)
//   full/empty : occupancy flags
//   count      : current occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module if_fifo
    import if_pkg::*;
#(
    parameter int unsigned  DEPTH = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  if_entry_t        push_data,
    output if_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    if_entry_t        mem_q [DEPTH];
    if_entry_t        mem_d [DEPTH];
    logic             do_push, do_pop;

    // Occupancy flags, guarded push/pop and next-state.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // Queue state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage: instruction-fetch stage with a small prefetch queue.
//   Parameters : RESET_PC (fetch PC after reset), QDEPTH (queue entries, 2 or 4)
//   clk, rst_n           : clock, asynchronous active-low reset
//   stall                : downstream holds IF/ID, head is not popped
//   redirect/redirect_pc : taken branch/jump, flushes and restarts fetch
//   imem_req/imem_addr   : memory request and word address
//   imem_gnt             : request accepted this cycle
//   imem_rvalid/rdata    : in-order read response
//   if_valid/pc_out/instr_out : presented instruction (NOP/0 when invalid)
// Build option: define IF_BYPASS_EN to forward a response straight to the
// outputs when the queue is empty (one cycle less fetch latency).
// -----------------------------------------------------------------------------
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IF_RESET_PC,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] pc_out,
    output logic [31:0] instr_out
);

    // Counters hold up to 2*QDEPTH: live requests plus responses still to drop.
    localparam int unsigned CNT_W = $clog2(2 * QDEPTH + 1);
    localparam int unsigned OCC_W = $clog2(QDEPTH + 1);

    logic [31:0]      fpc_q, fpc_d;
    logic [31:0]      rpc_q, rpc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0] occ_after_pop;
    logic [CNT_W-1:0] in_flight;
    logic [CNT_W-1:0] mem_pending;
    logic             grant;
    logic             rsp_keep;
    logic             rsp_drop;
    logic             byp_hit;

    logic             q_push, q_pop, q_full, q_empty;
    logic [OCC_W-1:0] q_count;
    if_entry_t        q_head, q_in;

    // Request generation and response classification.
    always_comb begin
        rsp_drop = imem_rvalid && (discard_q != '0);
        rsp_keep = rst_n && imem_rvalid && (discard_q == '0);
        q_pop    = !q_empty && !stall && !redirect;

        // A slot freed by this cycle's pop already counts as room, so a
        // steady stream with QDEPTH=2 can fetch every cycle.
        occ_after_pop = CNT_W'(q_count) - CNT_W'(q_pop);
        in_flight     = outstanding_q + occ_after_pop;
        mem_pending   = outstanding_q + discard_q;

        // The mem_pending bound keeps the discard counter from overflowing
        // across back-to-back redirects.
        imem_req  = rst_n && !redirect
                    && (in_flight < CNT_W'(QDEPTH))
                    && (mem_pending < CNT_W'(2 * QDEPTH));
        imem_addr = word_align(fpc_q);
        grant     = imem_req && imem_gnt;

        q_in.pc    = rpc_q;
        q_in.instr = imem_rdata;

`ifdef IF_BYPASS_EN
        // Empty queue and a live response: show it directly, keep it only
        // if the consumer is stalled.
        byp_hit = q_empty && rsp_keep && !redirect;
        q_push  = rsp_keep && !redirect && (!q_empty || stall) && (!q_full || q_pop);
`else
        byp_hit = 1'b0;
        q_push  = rsp_keep && !redirect && (!q_full || q_pop);
`endif
    end

    // Presented instruction; a redirect squashes it in the same cycle.
    always_comb begin
        if_valid  = 1'b0;
        pc_out    = '0;
        instr_out = NOP_INSTR;
        if (!redirect) begin
            if (!q_empty) begin
                if_valid  = 1'b1;
                pc_out    = q_head.pc;
                instr_out = q_head.instr;
            end else if (byp_hit) begin
                if_valid  = 1'b1;
                pc_out    = rpc_q;
                instr_out = imem_rdata;
            end
        end
    end

    // Fetch PC, response PC and request bookkeeping.
    always_comb begin
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;

        if (redirect) begin
            // Every request still in memory becomes a response to drop; a
            // response arriving right now is dropped as well.
            fpc_d         = word_align(redirect_pc);
            rpc_d         = word_align(redirect_pc);
            discard_d     = mem_pending - CNT_W'(imem_rvalid && (mem_pending != '0));
            outstanding_d = '0;
        end else begin
            if (grant) begin
                fpc_d = fpc_q + 32'd4;
            end
            // Responses return in grant order, so the next kept response
            // always belongs to rpc.
            if (rsp_keep) begin
                rpc_d = rpc_q + 32'd4;
            end
            if (rsp_drop) begin
                discard_d = discard_q - CNT_W'(1);
            end
            outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(rsp_keep);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q         <= RESET_PC;
            rpc_q         <= word_align(RESET_PC);
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    if_fifo #(
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (redirect),
        .push_data (q_in),
        .head      (q_head),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count)
    );

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage: directed self-checking bench for if_stage (QDEPTH=2).
// Memory model: answers each grant in order one cycle later; mem_hold parks
// responses so several requests can be outstanding.
// Instruction word at address a is {16'hC0DE, a[15:0]}.
// -----------------------------------------------------------------------------
module tb_if_stage;

`ifdef IF_BYPASS_EN
    localparam int unsigned BYP = 1;
`else
    localparam int unsigned BYP = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] nxt;
    logic [31:0] exp_addr;
    bit          mem_hold = 1'b0;
    logic [31:0] mq [$];

    if_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .pc_out      (pc_out),
        .instr_out   (instr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: log this cycle's grant, then present the memory response.
    task automatic step();
        if (rst_n && imem_req && imem_gnt) mq.push_back(imem_addr);
        @(posedge clk);
        #1;
        if (!mem_hold && mq.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end
    endtask

    // Wait (bounded) for the next presented instruction and check it is nxt.
    task automatic expect_next(input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            #1;
            if (if_valid) begin
                found = 1'b1;
                chk({tag, "_pc"}, pc_out, nxt);
                chk({tag, "_instr"}, instr_out, mem_word(nxt));
                nxt = nxt + 32'd4;
            end
            step();
        end
        chk({tag, "_seen"}, 32'(found), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=no_summary required=finish");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        // Reset state
        #1;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc",    pc_out,        32'h0);
        chk("rst_instr", instr_out,     32'h0);
        step();
        step();

        // First request to RESET_PC right after release, then a steady stream
        rst_n = 1'b1;
        #1;
        chk("c0_req",   32'(imem_req), 32'd1);
        chk("c0_addr",  imem_addr,     32'h0);
        chk("c0_valid", 32'(if_valid), 32'd0);
        step();
        #1;
        chk("c1_addr",  imem_addr,     32'h4);
        chk("c1_valid", 32'(if_valid), 32'(BYP));
        chk("c1_pc",    pc_out,        32'h0);
        chk("c1_instr", instr_out,     (BYP != 0) ? mem_word(32'h0) : 32'h0);
        step();
        for (int k = 2; k <= 4; k++) begin
            #1;
            chk("seq_valid", 32'(if_valid), 32'd1);
            chk("seq_pc",    pc_out,        32'(4 * (k - 2 + int'(BYP))));
            chk("seq_instr", instr_out,     mem_word(32'(4 * (k - 2 + int'(BYP)))));
            step();
        end
        nxt = 32'(4 * (3 + int'(BYP)));

        // Stall for 5 cycles: queue fills, requests stop, head is held
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_pc",    pc_out,        nxt);
            chk("stall_instr", instr_out,     mem_word(nxt));
            if (i > 0) chk("stall_req", 32'(imem_req), 32'd0);
            step();
        end
        stall = 1'b0;
        for (int i = 0; i < 4; i++) expect_next("post_stall");

        // Park two requests in memory, then redirect to an unaligned target
        mem_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (if_valid) begin
                chk("hold_pc", pc_out, nxt);
                nxt = nxt + 32'd4;
            end
            step();
        end
        #1;
        chk("hold_valid", 32'(if_valid), 32'd0);
        chk("hold_req",   32'(imem_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        mem_hold    = 1'b0;
        #1;
        chk("redir_valid", 32'(if_valid), 32'd0);
        chk("redir_req",   32'(imem_req), 32'd0);
        chk("redir_instr", instr_out,     32'h0);
        step();
        redirect = 1'b0;
        #1;
        chk("redir_next_req",  32'(imem_req), 32'd1);
        chk("redir_next_addr", imem_addr,     32'h0000_0100);
        nxt = 32'h0000_0100;
        for (int i = 0; i < 3; i++) expect_next("redir");

        // Redirect and stall together: redirect wins, queue flushed
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        #1;
        chk("rs_valid", 32'(if_valid), 32'd0);
        chk("rs_pc",    pc_out,        32'h0);
        chk("rs_instr", instr_out,     32'h0);
        chk("rs_req",   32'(imem_req), 32'd0);
        step();
        stall    = 1'b0;
        redirect = 1'b0;
        nxt      = 32'h0000_0200;
        for (int i = 0; i < 2; i++) expect_next("rs");

        // Grant withheld for 3 cycles: address frozen, queue drains
        imem_gnt = 1'b0;
        exp_addr = nxt + ((BYP != 0) ? 32'd4 : 32'd8);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nognt_addr", imem_addr,     exp_addr);
            chk("nognt_req",  32'(imem_req), 32'd1);
            if (if_valid) begin
                chk("nognt_pc", pc_out, nxt);
                nxt = nxt + 32'd4;
            end
            if (i == 2) chk("nognt_drained", 32'(if_valid), 32'd0);
            step();
        end
        imem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) expect_next("regnt");

        // Asynchronous reset mid-stream, then restart from RESET_PC
        rst_n       = 1'b0;
        mq.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        #1;
        chk("arst_valid", 32'(if_valid), 32'd0);
        chk("arst_pc",    pc_out,        32'h0);
        chk("arst_instr", instr_out,     32'h0);
        chk("arst_req",   32'(imem_req), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("restart_req",  32'(imem_req), 32'd1);
        chk("restart_addr", imem_addr,     32'h0);
        nxt = 32'h0;
        for (int i = 0; i < 3; i++) expect_next("restart");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
